// File: rtl/float_discriminant_arbiter_pkg.sv
// rtl/float_discriminant_arbiter_pkg.sv - shared types for the float_discriminant arbiter
package float_discriminant_arbiter_pkg;

  // Operand/result width of the shared IEEE double-precision discriminant unit.
  localparam int FLEN = 64;
  localparam int N_REQ_DFLT = 4;

  typedef logic [FLEN-1:0] flt_t;
  typedef logic [$clog2(N_REQ_DFLT)-1:0] req_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GUARD = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/fd_arb_id_fifo.sv
// rtl/fd_arb_id_fifo.sv - in-order FIFO of issued requester IDs
module fd_arb_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_id,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage array; contents are don't-care while the matching slot is empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_id;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/float_discriminant_arbiter.sv
// rtl/float_discriminant_arbiter.sv - round-robin sharing of one float_discriminant unit; FD_ARB_TIMEOUT_EN adds a result watchdog
module float_discriminant_arbiter
  import float_discriminant_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int ID_FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_vld,
  output logic [N_REQ-1:0]      req_rdy,
  input  logic [N_REQ*FLEN-1:0] req_a,
  input  logic [N_REQ*FLEN-1:0] req_b,
  input  logic [N_REQ*FLEN-1:0] req_c,
  output logic [N_REQ-1:0]      rsp_vld,
  output logic [FLEN-1:0]       rsp_res,
  output logic                  rsp_negative,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  spurious,
  output logic                  du_arg_vld,
  output logic [FLEN-1:0]       du_a,
  output logic [FLEN-1:0]       du_b,
  output logic [FLEN-1:0]       du_c,
  input  logic                  du_busy,
  input  logic                  du_res_vld,
  input  logic                  du_res_negative,
  input  logic                  du_err,
  input  logic [FLEN-1:0]       du_res
);

  localparam int ID_W = $clog2(N_REQ);

  fsm_state_t       r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  flt_t             r_du_a;
  flt_t             r_du_b;
  flt_t             r_du_c;
  logic [N_REQ-1:0] r_rsp_vld;
  flt_t             r_rsp_res;
  logic             r_rsp_negative;
  logic             r_rsp_err;
  logic             r_spurious;

  logic [ID_W-1:0]  w_winner;
  logic [ID_W-1:0]  w_head_id;
  logic             w_can_grant;
  logic             w_push;
  logic             w_res_pop;
  logic             w_pop;
  logic             w_timeout;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  // First asserted request at or after ptr, scanning upward with wrap.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                               input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] win;
    int              idx;
    win = ptr;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (vld[idx]) win = ID_W'(idx);
    end
    return win;
  endfunction

  function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  assign w_winner = rr_pick(req_vld, r_rr_ptr);

  // rst is folded in so req_rdy is also 0 while reset is held.
  assign w_can_grant = rst && (r_state == IDLE) && (|req_vld) && !du_busy && !w_fifo_full;
  assign req_rdy     = w_can_grant ? id_onehot(w_winner) : '0;
  assign w_push      = |(req_vld & req_rdy);

  assign du_arg_vld   = (r_state == ISSUE);
  assign du_a         = r_du_a;
  assign du_b         = r_du_b;
  assign du_c         = r_du_c;
  assign rsp_vld      = r_rsp_vld;
  assign rsp_res      = r_rsp_res;
  assign rsp_negative = r_rsp_negative;
  assign rsp_err      = r_rsp_err;
  assign spurious     = r_spurious;

  assign w_res_pop = du_res_vld && !w_fifo_empty;
  assign w_pop     = w_res_pop || w_timeout;

  fd_arb_id_fifo #(
    .W     (ID_W),
    .DEPTH (ID_FIFO_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .i_rst_n   (rst),
    .i_push    (w_push),
    .i_push_id (w_winner),
    .i_pop     (w_pop),
    .o_head    (w_head_id),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // Issue sequencer: one operand strobe, then a bubble so du_busy settles before the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_push) r_state <= ISSUE;
        ISSUE:   r_state <= GUARD;
        GUARD:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Operand capture and round-robin pointer advance on each grant handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_du_a   <= '0;
      r_du_b   <= '0;
      r_du_c   <= '0;
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_du_a   <= req_a[w_winner*FLEN +: FLEN];
      r_du_b   <= req_b[w_winner*FLEN +: FLEN];
      r_du_c   <= req_c[w_winner*FLEN +: FLEN];
      r_rr_ptr <= (w_winner == ID_W'(N_REQ-1)) ? '0 : w_winner + 1'b1;
    end
  end

`ifdef FD_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_rsp_timeout;

  // A real result arriving on the expiry cycle takes precedence over the watchdog.
  assign w_timeout   = !w_fifo_empty && !du_res_vld && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES-1));
  assign rsp_timeout = r_rsp_timeout;

  // Watchdog: cycles spent waiting on the FIFO head; restarts on every pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt <= '0;
    end else if (w_fifo_empty || w_pop) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  // Timeout flag travels with the response it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_pop) begin
      r_rsp_timeout <= w_timeout;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // Response routing: one-hot strobe to the FIFO head owner, one cycle after the pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_vld      <= '0;
      r_rsp_res      <= '0;
      r_rsp_negative <= 1'b0;
      r_rsp_err      <= 1'b0;
      r_spurious     <= 1'b0;
    end else begin
      r_rsp_vld <= '0;
      if (w_res_pop) begin
        r_rsp_vld      <= id_onehot(w_head_id);
        r_rsp_res      <= du_res;
        r_rsp_negative <= du_res_negative;
        r_rsp_err      <= du_err;
      end else if (w_timeout) begin
        r_rsp_vld      <= id_onehot(w_head_id);
        r_rsp_res      <= '0;
        r_rsp_negative <= 1'b0;
        r_rsp_err      <= 1'b1;
      end
      if (du_res_vld && w_fifo_empty) r_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_float_discriminant_arbiter.sv
// tb/tb_float_discriminant_arbiter.sv - directed bench for float_discriminant_arbiter
module tb_float_discriminant_arbiter;
  import float_discriminant_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TO = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_vld = '0;
  logic [N-1:0]      req_rdy;
  logic [N*FLEN-1:0] req_a = '0;
  logic [N*FLEN-1:0] req_b = '0;
  logic [N*FLEN-1:0] req_c = '0;
  logic [N-1:0]      rsp_vld;
  logic [FLEN-1:0]   rsp_res;
  logic              rsp_negative, rsp_err, rsp_timeout, spurious;
  logic              du_arg_vld;
  logic [FLEN-1:0]   du_a, du_b, du_c;
  logic              du_busy = 1'b0;
  logic              u_err = 1'b0;
  wire               du_res_vld, du_res_negative;
  wire  [FLEN-1:0]   du_res;

  // unit model: fixed 2-cycle latency, plus a manual injection port
  logic              model_en = 1'b1;
  logic              p0v = 1'b0, p1v = 1'b0, m_vld = 1'b0, m_neg = 1'b0;
  logic [FLEN-1:0]   p0r = '0, p1r = '0, m_res = '0;
  logic              t_vld = 1'b0;
  logic [FLEN-1:0]   t_res = '0;

  assign du_res_vld      = m_vld | t_vld;
  assign du_res          = m_vld ? m_res : t_res;
  assign du_res_negative = m_vld & m_neg;

  int n_vec = 0;
  int n_bad = 0;
  int g_ids[$];
  int g_cyc[$];
  int r_ids[$];

  typedef struct {
    int          idx;
    real         a, b, c;
    logic [63:0] exp_res;
    logic        exp_neg;
  } vec_t;

  vec_t vt[5];

  always #5 clk = ~clk;

  float_discriminant_arbiter #(
    .N_REQ          (N),
    .ID_FIFO_DEPTH  (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_vld         (req_vld),
    .req_rdy         (req_rdy),
    .req_a           (req_a),
    .req_b           (req_b),
    .req_c           (req_c),
    .rsp_vld         (rsp_vld),
    .rsp_res         (rsp_res),
    .rsp_negative    (rsp_negative),
    .rsp_err         (rsp_err),
    .rsp_timeout     (rsp_timeout),
    .spurious        (spurious),
    .du_arg_vld      (du_arg_vld),
    .du_a            (du_a),
    .du_b            (du_b),
    .du_c            (du_c),
    .du_busy         (du_busy),
    .du_res_vld      (du_res_vld),
    .du_res_negative (du_res_negative),
    .du_err          (u_err),
    .du_res          (du_res)
  );

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      p0v = 1'b0; p1v = 1'b0; m_vld = 1'b0; m_neg = 1'b0;
    end else begin
      p1v = p0v;
      p1r = p0r;
      p0v = model_en && du_arg_vld;
      if (p0v) p0r = $realtobits($bitstoreal(du_b) * $bitstoreal(du_b)
                                 - 4.0 * $bitstoreal(du_a) * $bitstoreal(du_c));
      m_vld = p1v;
      m_res = p1r;
      m_neg = p1v && ($bitstoreal(p1r) < 0.0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_req(input int i, input real a, input real b, input real c);
    req_a[i*FLEN +: FLEN] = $realtobits(a);
    req_b[i*FLEN +: FLEN] = $realtobits(b);
    req_c[i*FLEN +: FLEN] = $realtobits(c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_vld = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_rdy(input int idx, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_rdy[idx]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("wait_rdy_timeout", 64'(req_rdy), 64'(1) << idx);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    bit ok;
    @(negedge clk);
    set_req(v.idx, v.a, v.b, v.c);
    req_vld[v.idx] = 1'b1;
    wait_rdy(v.idx, ok);
    @(negedge clk);
    req_vld = '0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (|rsp_vld) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk($sformatf("v%0d_rsp_vld", n), 64'(rsp_vld), 64'(1) << v.idx);
    chk($sformatf("v%0d_rsp_res", n), rsp_res, v.exp_res);
    chk($sformatf("v%0d_rsp_neg", n), 64'(rsp_negative), 64'(v.exp_neg));
    chk($sformatf("v%0d_rsp_err", n), 64'(rsp_err), 64'(0));
    chk($sformatf("v%0d_rsp_to", n), 64'(rsp_timeout), 64'(0));
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_rsp_pulse", n), 64'(rsp_vld), 64'(0));
  endtask

  task automatic arb_run(input logic [N-1:0] mask, input bit hold, input int ngr);
    logic [N-1:0] clr;
    bit stop;
    g_ids.delete(); g_cyc.delete(); r_ids.delete();
    stop = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 1.0, 4.0, 3.0);
    req_vld = mask;
    for (int cyc = 0; cyc < 300; cyc++) begin
      #1;
      clr = '0;
      if (|req_rdy) begin
        g_ids.push_back(oh2i(req_rdy));
        g_cyc.push_back(cyc);
        if (!hold) clr = req_rdy;
        if (g_ids.size() == ngr) stop = 1'b1;
      end
      if (|rsp_vld) r_ids.push_back(oh2i(rsp_vld));
      if (r_ids.size() >= ngr) break;
      @(negedge clk);
      req_vld = stop ? '0 : (req_vld & ~clr);
    end
    req_vld = '0;
    chk("arb_rsp_count", 64'(r_ids.size()), 64'(ngr));
  endtask

  initial begin
    int  exp4[6];
    bit  flag;
    bit  ok;
    int  n;

    vt[0] = '{0, 1.0, 4.0, 3.0, $realtobits(4.0),  1'b0};
    vt[1] = '{1, 1.0, 1.0, 1.0, $realtobits(-3.0), 1'b1};
    vt[2] = '{2, 2.0, 3.0, 1.0, $realtobits(1.0),  1'b0};
    vt[3] = '{3, 0.5, 0.0, 2.0, $realtobits(-4.0), 1'b1};
    vt[4] = '{0, 1.0, 2.0, 1.0, 64'h0,             1'b0};
    exp4  = '{0, 2, 0, 2, 0, 2};

    // reset state, with requests asserted while reset is held
    req_vld = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_rdy", 64'(req_rdy), 64'(0));
    chk("rst_du_arg_vld", 64'(du_arg_vld), 64'(0));
    chk("rst_rsp_vld", 64'(rsp_vld), 64'(0));
    chk("rst_spurious", 64'(spurious), 64'(0));
    chk("rst_du_a", du_a, 64'(0));
    req_vld = '0;
    @(negedge clk);
    rst = 1'b1;

    // all four requesting from reset
    arb_run(4'b1111, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_ids.size()) chk($sformatf("t3_grant%0d", i), 64'(g_ids[i]), 64'(i));
      if (i < r_ids.size()) chk($sformatf("t3_rsp%0d", i), 64'(r_ids[i]), 64'(i));
      if (i > 0 && i < g_cyc.size())
        chk($sformatf("t3_space%0d", i), 64'(g_cyc[i] - g_cyc[i-1] >= 3), 64'(1));
    end

    // table vectors
    for (int i = 0; i < 5; i++) run_vec(vt[i], i);

    // two persistent requesters alternate
    do_reset();
    arb_run(4'b0101, 1'b1, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < g_ids.size()) chk($sformatf("t4_grant%0d", i), 64'(g_ids[i]), 64'(exp4[i]));
      if (i < r_ids.size()) chk($sformatf("t4_rsp%0d", i), 64'(r_ids[i]), 64'(exp4[i]));
    end

    // busy unit blocks grants; release resumes at rr_ptr (3, after last grant to 2)
    repeat (4) @(negedge clk);
    du_busy = 1'b1;
    req_vld = '1;
    flag = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (req_rdy != '0 || du_arg_vld) flag = 1'b1;
      @(negedge clk);
    end
    chk("t5_busy_blocks", 64'(flag), 64'(0));
    du_busy = 1'b0;
    #1;
    chk("t5_release_grant", 64'(req_rdy), 64'(4'b1000));
    @(negedge clk);
    req_vld = '0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (|rsp_vld) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("t5_rsp_vld", 64'(rsp_vld), 64'(4'b1000));
    repeat (4) @(negedge clk);

    // result with empty ID FIFO
    t_vld = 1'b1;
    t_res = 64'h1234;
    @(negedge clk);
    t_vld = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (rsp_vld != '0) flag = 1'b1;
      @(negedge clk);
    end
    chk("t6_spurious_no_rsp", 64'(flag), 64'(0));
    chk("t6_spurious_flag", 64'(spurious), 64'(1));

    // reset during GUARD
    do_reset();
    #1;
    chk("t6_spurious_cleared", 64'(spurious), 64'(0));
    @(negedge clk);
    set_req(1, 3.0, 5.0, 7.0);
    req_vld[1] = 1'b1;
    wait_rdy(1, ok);
    @(negedge clk);
    req_vld = '0;
    #1;
    chk("t6_issue_strobe", 64'(du_arg_vld), 64'(1));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_du_arg_vld", 64'(du_arg_vld), 64'(0));
    chk("t6_rst_du_a", du_a, 64'(0));
    chk("t6_rst_du_b", du_b, 64'(0));
    chk("t6_rst_du_c", du_c, 64'(0));
    chk("t6_rst_rsp_vld", 64'(rsp_vld), 64'(0));
    chk("t6_rst_rsp_res", rsp_res, 64'(0));
    chk("t6_rst_flags", 64'({rsp_negative, rsp_err, rsp_timeout, spurious}), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (rsp_vld != '0) flag = 1'b1;
      @(negedge clk);
    end
    chk("t6_no_lost_rsp", 64'(flag), 64'(0));
    t_vld = 1'b1;
    @(negedge clk);
    t_vld = 1'b0;
    #1;
    chk("t6_fifo_empty_after_rst", 64'(spurious), 64'(1));

`ifdef FD_ARB_TIMEOUT_EN
    // unit never answers
    do_reset();
    model_en = 1'b0;
    @(negedge clk);
    set_req(2, 1.0, 1.0, 1.0);
    req_vld[2] = 1'b1;
    wait_rdy(2, ok);
    n = 0;
    ok = 1'b0;
    for (int k = 0; k < TO + 20; k++) begin
      @(negedge clk);
      req_vld = '0;
      n++;
      #1;
      if (|rsp_vld) begin ok = 1'b1; break; end
    end
    chk("t7_latency", 64'(n), 64'(TO + 1));
    chk("t7_rsp_vld", 64'(rsp_vld), 64'(4'b0100));
    chk("t7_rsp_err", 64'(rsp_err), 64'(1));
    chk("t7_rsp_timeout", 64'(rsp_timeout), 64'(1));
    chk("t7_rsp_res", rsp_res, 64'(0));
    model_en = 1'b1;
`else
    n = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
